// File: rtl/speed_avg_calc.sv
// Wheel speed from a moving average of reed-switch periods, with bounce rejection,
// stop detection and a request/busy/ready handshake to a shared external divider.
module speed_avg_calc #(
    parameter int          CNT_W      = 16,
    parameter int          SPEED_W    = 7,
    parameter int          AVG_DEPTH  = 4,
    parameter logic [15:0] CONST      = 16'h49BA,
    parameter int          SPEED_MAX  = 99,
    parameter int          TIMEOUT    = 4000,
    parameter int          MIN_PERIOD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               reed,
    input  logic [7:0]         circ,
    input  logic               start,
    input  logic               div_busy,
    input  logic               div_ready,
    input  logic [CNT_W-1:0]   div_result,
    output logic               div_req,
    output logic [CNT_W-1:0]   div_dividend,
    output logic [CNT_W-1:0]   div_divisor,
    output logic [SPEED_W-1:0] speed,
    output logic               valid,
    output logic               stalled
);
    localparam int AW     = $clog2(AVG_DEPTH);
    localparam int SUM_W  = CNT_W + AW;
    localparam int FILL_W = $clog2(AVG_DEPTH + 1);
    localparam int PROD_W = CNT_W + 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, DONE0, REQ, WBUSY, WDONE} state_t;

    logic [CNT_W-1:0]  cnt_q;
    logic              reed_q;
    logic [CNT_W-1:0]  samp_q [AVG_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [SUM_W-1:0]  sum_q;
    logic [FILL_W-1:0] fill_q;
    logic [CNT_W-1:0]  last_q;
    logic              stalled_q;

    logic              sample_accept;
    logic [CNT_W-1:0]  divisor_now;
    logic [CNT_W-1:0]  dividend_now;
    logic [SPEED_W-1:0] speed_sat;

    state_t            state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  dividend_q, dividend_d;
    logic [CNT_W-1:0]  divisor_q, divisor_d;

    // Short periods are contact bounce: the edge is dropped and counting carries on.
    assign sample_accept = reed && !reed_q && (cnt_q >= CNT_W'(MIN_PERIOD));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            reed_q    <= 1'b0;
            wr_ptr_q  <= '0;
            sum_q     <= '0;
            fill_q    <= '0;
            last_q    <= '0;
            stalled_q <= 1'b0;
            for (int i = 0; i < AVG_DEPTH; i++) begin
                samp_q[i] <= '0;
            end
        end else begin
            reed_q    <= reed;
            stalled_q <= (cnt_q > CNT_W'(TIMEOUT));
            if (sample_accept) begin
                samp_q[wr_ptr_q] <= cnt_q;
                sum_q            <= sum_q + SUM_W'(cnt_q) - SUM_W'(samp_q[wr_ptr_q]);
                wr_ptr_q         <= wr_ptr_q + AW'(1);
                last_q           <= cnt_q;
                if (fill_q != FILL_W'(AVG_DEPTH)) begin
                    fill_q <= fill_q + FILL_W'(1);
                end
                cnt_q <= '0;
            end else if (en && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Until the window is full the latest period stands in for the average.
    assign divisor_now  = (fill_q == FILL_W'(AVG_DEPTH)) ? CNT_W'(sum_q >> AW) : last_q;
    assign dividend_now = CNT_W'((PROD_W'(circ) * PROD_W'(CONST)) >> 8);
    assign speed_sat    = (div_result > CNT_W'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX)
                                                           : div_result[SPEED_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            speed_q    <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
        end else begin
            state_q    <= state_d;
            speed_q    <= speed_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        speed_d    = speed_q;
        valid_d    = valid_q;
        req_d      = 1'b0;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    valid_d = 1'b0;
                    state_d = (stalled_q || (fill_q == '0)) ? DONE0 : REQ;
                end
            end
            DONE0: begin
                speed_d = '0;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            REQ: begin
                if (divisor_now == '0) begin
                    speed_d = SPEED_W'(SPEED_MAX);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (!div_busy) begin
                    dividend_d = dividend_now;
                    divisor_d  = divisor_now;
                    req_d      = 1'b1;
                    state_d    = WBUSY;
                end
            end
            WBUSY: begin
                if (div_busy) begin
                    state_d = WDONE;
                end
            end
            WDONE: begin
                if (div_ready) begin
                    speed_d = speed_sat;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign div_req      = req_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign speed        = speed_q;
    assign valid        = valid_q;
    assign stalled      = stalled_q;
endmodule

// File: tb/tb_speed_avg_calc.sv
// Randomised bench for speed_avg_calc: a period-queue model predicts stalled, divider
// operands and speed; directed scenarios pin the model with hand-computed values.
module tb_speed_avg_calc;
    localparam int CNT_W      = 16;
    localparam int SPEED_W    = 7;
    localparam int AVG_DEPTH  = 4;
    localparam int SPEED_MAX  = 99;
    localparam int TIMEOUT    = 4000;
    localparam int MIN_PERIOD = 8;
    localparam int CONST_I    = 18874;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, reed = 1'b0, start = 1'b0;
    logic [7:0] circ = 8'd0;
    logic div_busy, div_ready;
    logic [CNT_W-1:0] div_result;
    logic div_req;
    logic [CNT_W-1:0] div_dividend, div_divisor;
    logic [SPEED_W-1:0] speed;
    logic valid, stalled;

    always #5 clk = ~clk;

    speed_avg_calc #(
        .CNT_W(CNT_W), .SPEED_W(SPEED_W), .AVG_DEPTH(AVG_DEPTH), .CONST(16'h49BA),
        .SPEED_MAX(SPEED_MAX), .TIMEOUT(TIMEOUT), .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .reed(reed), .circ(circ), .start(start),
        .div_busy(div_busy), .div_ready(div_ready), .div_result(div_result),
        .div_req(div_req), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .speed(speed), .valid(valid), .stalled(stalled)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // External divider: true quotient, random latency, optional forced busy.
    logic ext_busy = 1'b0, late_ready = 1'b0;
    logic dv_busy = 1'b0, dv_ready = 1'b0;
    logic [CNT_W-1:0] dv_result = '0;
    int busy_len_cfg = 0;
    assign div_busy   = ext_busy | dv_busy;
    assign div_ready  = dv_ready | late_ready;
    assign div_result = late_ready ? 16'd42 : dv_result;

    initial begin
        int st, dly, len;
        st = 0; dly = 0; len = 0;
        forever begin
            @(posedge clk); #2;
            dv_ready = 1'b0;
            if (rst) begin
                st = 0; dv_busy = 1'b0;
            end else begin
                case (st)
                    0: if (div_req) begin
                        dv_result = (div_divisor == 0) ? '1 : div_dividend / div_divisor;
                        dly = $urandom_range(0, 2);
                        len = (busy_len_cfg != 0) ? busy_len_cfg : $urandom_range(1, 5);
                        if (dly == 0) begin dv_busy = 1'b1; st = 2; end
                        else st = 1;
                    end
                    1: begin
                        dly--;
                        if (dly == 0) begin dv_busy = 1'b1; st = 2; end
                    end
                    default: begin
                        len--;
                        if (len == 0) begin dv_busy = 1'b0; dv_ready = 1'b1; st = 0; end
                    end
                endcase
            end
        end
    end

    // Behavioural model: tick counter plus a queue of the last AVG_DEPTH accepted periods.
    int m_cnt = 0;
    int m_q[$];
    bit m_reed_prev = 1'b0;
    bit m_stalled = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_q.delete(); m_reed_prev = 1'b0; m_stalled = 1'b0;
        end else begin
            m_stalled = (m_cnt > TIMEOUT);
            if (reed && !m_reed_prev && m_cnt >= MIN_PERIOD) begin
                m_q.push_back(m_cnt);
                if (m_q.size() > AVG_DEPTH) void'(m_q.pop_front());
                m_cnt = 0;
            end else if (en && m_cnt < (1 << CNT_W) - 1) begin
                m_cnt++;
            end
            m_reed_prev = reed;
        end
    end

    function automatic int model_divisor();
        int s = 0;
        if (m_q.size() == 0) return 0;
        if (m_q.size() < AVG_DEPTH) return m_q[m_q.size() - 1];
        foreach (m_q[i]) s += m_q[i];
        return s / AVG_DEPTH;
    endfunction

    // Compare process: outputs seen here follow the previous edge; pend_* hold the
    // inputs and model state that edge acted on.
    bit pend_rst = 1'b1, pend_accept = 1'b0, pend_busy = 1'b0;
    int pend_dividend = 0, pend_divisor = 0;
    bit txn_active = 1'b0, txn_zero = 1'b0;
    int txn_cyc = 0, exp_speed = 0, q;
    bit prev_valid = 1'b0, prev_req = 1'b0;
    int n_req = 0, cap_dividend = 0, cap_divisor = 0;

    always @(negedge clk) begin
        if (pend_rst) begin
            check("reset_speed", speed, 0);
            check("reset_valid", valid, 0);
            check("reset_div_req", div_req, 0);
            check("reset_stalled", stalled, 0);
            txn_active = 1'b0;
        end else begin
            if (txn_active) txn_cyc++;
            if (pend_accept) check("valid_cleared_on_start", valid, 0);
            if (div_req) begin
                n_req++;
                check("req_in_divider_txn", txn_active && !txn_zero, 1);
                check("req_while_busy", pend_busy, 0);
                check("req_single_cycle", prev_req, 0);
                check("dividend", div_dividend, pend_dividend);
                check("divisor", div_divisor, pend_divisor);
                cap_dividend = div_dividend;
                cap_divisor  = div_divisor;
                q = (pend_divisor == 0) ? SPEED_MAX : pend_dividend / pend_divisor;
                exp_speed = (q > SPEED_MAX) ? SPEED_MAX : q;
            end
            if (valid && !prev_valid) begin
                check("valid_rise_expected", txn_active, 1);
                if (txn_zero) check("zero_path_latency", txn_cyc, 2);
                txn_active = 1'b0;
            end
            if (valid) check("speed", speed, exp_speed);
            if (txn_active && txn_cyc > 3000) begin
                check("txn_timeout_cycles", txn_cyc, 3000);
                txn_active = 1'b0;
            end
            check("stalled", stalled, m_stalled);
        end
        prev_valid    = valid;
        prev_req      = div_req;
        pend_rst      = rst;
        pend_busy     = div_busy;
        pend_dividend = (int'(circ) * CONST_I) >> 8;
        pend_divisor  = model_divisor();
        pend_accept   = start && !txn_active && !rst;
        if (pend_accept) begin
            txn_active = 1'b1;
            txn_cyc    = 0;
            txn_zero   = m_stalled || (m_q.size() == 0);
            if (txn_zero) exp_speed = 0;
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the active edge.
    task automatic cyc(input bit en_v, input bit reed_v, input bit start_v);
        @(posedge clk); #1;
        en = en_v; reed = reed_v; start = start_v;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; en = 1'b0; reed = 1'b0; start = 1'b0;
        repeat (3) cyc(0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1, 0, 0);
    endtask

    // n ticks, then a rising reed edge (en on that cycle = sim), then reed low.
    task automatic period(input int n, input bit sim);
        ticks(n);
        cyc(sim, 1, 0);
        cyc(0, 0, 0);
    endtask

    task automatic rand_period(input int n);
        int done = 0;
        while (done < n) begin
            if ($urandom_range(0, 3) == 0) cyc(0, 0, 0);
            else begin cyc(1, 0, 0); done++; end
        end
        cyc(1'($urandom_range(0, 1)), 1, 0);
        cyc(0, 0, 0);
    endtask

    task automatic pulse_start();
        cyc(0, 0, 1);
        cyc(0, 0, 0);
    endtask

    task automatic wait_valid(input int max, input bit rand_en);
        int k = 0;
        while (!valid && k < max) begin
            cyc(rand_en ? 1'($urandom_range(0, 1)) : 1'b0, 0, 0);
            k++;
        end
        check("wait_valid", valid, 1);
    endtask

    initial begin
        int req0, n;
        circ = 8'd210;
        do_reset();
        check("post_reset_valid", valid, 0);
        check("post_reset_speed", speed, 0);

        // Four equal periods of 200
        repeat (4) period(200, 0);
        req0 = n_req;
        pulse_start();
        wait_valid(100, 0);
        check("s1_req_count", n_req - req0, 1);
        check("s1_dividend", cap_dividend, 15482);
        check("s1_divisor", cap_divisor, 200);
        check("s1_speed", speed, 77);

        // Moving average 200,200,200,400 then 200,200,400,200
        do_reset();
        period(200, 0); period(200, 0); period(200, 0); period(400, 0);
        pulse_start();
        wait_valid(100, 0);
        check("s2_divisor_a", cap_divisor, 250);
        check("s2_speed_a", speed, 61);
        period(200, 0);
        pulse_start();
        wait_valid(100, 0);
        check("s2_divisor_b", cap_divisor, 250);
        check("s2_speed_b", speed, 61);

        // Saturation, then the stall boundary
        do_reset();
        period(100, 0);
        pulse_start();
        wait_valid(100, 0);
        check("s3_divisor", cap_divisor, 100);
        check("s3_speed_sat", speed, 99);
        ticks(4000);
        repeat (2) cyc(0, 0, 0);
        check("s3_not_stalled_4000", stalled, 0);
        ticks(1);
        repeat (2) cyc(0, 0, 0);
        check("s3_stalled_4001", stalled, 1);
        req0 = n_req;
        pulse_start();
        wait_valid(10, 0);
        check("s3_stall_no_req", n_req - req0, 0);
        check("s3_stall_speed", speed, 0);

        // Bounce rejection and simultaneous en/edge
        do_reset();
        period(3, 0); period(2, 0); period(195, 0);
        pulse_start();
        wait_valid(100, 0);
        check("s4_bounce_divisor", cap_divisor, 200);
        period(120, 1);
        pulse_start();
        wait_valid(100, 0);
        check("s4_simul_divisor", cap_divisor, 120);
        period(100, 0);
        pulse_start();
        wait_valid(100, 0);
        check("s4_after_simul_divisor", cap_divisor, 100);

        // Busy hold, ignored starts, reset in WDONE, late ready
        do_reset();
        period(200, 0);
        busy_len_cfg = 30;
        ext_busy = 1'b1;
        req0 = n_req;
        pulse_start();
        repeat (5) begin cyc(0, 0, 1); cyc(0, 0, 0); end
        check("s5_req_held_off", n_req - req0, 0);
        ext_busy = 1'b0;
        n = 0;
        while (n_req == req0 && n < 20) begin cyc(0, 0, 0); n++; end
        check("s5_req_after_busy", n_req - req0, 1);
        n = 0;
        while (!div_busy && n < 20) begin cyc(0, 0, 1); n++; end
        repeat (3) begin cyc(0, 0, 1); cyc(0, 0, 0); end
        check("s5_no_extra_req", n_req - req0, 1);
        rst = 1'b1;
        repeat (2) cyc(0, 0, 0);
        rst = 1'b0;
        busy_len_cfg = 0;
        cyc(0, 0, 0);
        late_ready = 1'b1;
        cyc(0, 0, 0);
        late_ready = 1'b0;
        repeat (5) cyc(0, 0, 0);
        check("s5_late_ready_valid", valid, 0);
        check("s5_late_ready_speed", speed, 0);
        period(200, 0);
        pulse_start();
        wait_valid(100, 0);
        check("s5_recovered_speed", speed, 77);

        // Randomised rounds
        for (int r = 0; r < 25; r++) begin
            circ = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) do_reset();
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) period($urandom_range(0, 7), 0);
                rand_period($urandom_range(8, 200));
            end
            pulse_start();
            wait_valid(200, 1);
        end

        repeat (3) cyc(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule
